// File: rtl/control_multiciclo_hs.sv
// rtl/control_multiciclo_hs.sv - multicycle RV32I control FSM with memory handshake, timeout and trap
//
// Purpose: sequences fetch/decode/execute/memory/writeback for RV32I. Variable-latency
//          memory accesses use a mem_req/mem_ready handshake guarded by a wait counter.
//          Illegal opcodes and bus timeouts park the FSM in TRAP until trap_clear.
// Ports:
//   clk, reset_n           clock, asynchronous active-low reset
//   opcode/funct3/funct7   instruction register fields
//   mem_ready              memory access completes this cycle
//   trap_clear             leave TRAP and resume fetch
//   mem_req                memory request, held until mem_ready
//   PCWrite..ALUOutEn      datapath enables
//   PCSource..ALUOp        datapath selects, ImmSrc immediate format (0=I 1=S 2=B 3=U 4=J)
//   trap, trap_cause       trap flag and cause (1 illegal opcode, 2 bus timeout)
//   retire                 one-cycle pulse per completed instruction
//   st_dbg                 current state encoding
//   instret                retired-instruction counter (only with CTRL_INSTRET_EN)
// Optional feature macro: CTRL_INSTRET_EN
module control_multiciclo_hs #(
    parameter int TIMEOUT_W   = 8,
    parameter int TIMEOUT_MAX = 200
`ifdef CTRL_INSTRET_EN
    ,parameter int INSTRET_W  = 32
`endif
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       mem_ready,
    input  logic       trap_clear,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       LatchAB,
    output logic       ALUOutEn,
    output logic [1:0] PCSource,
    output logic [1:0] MemtoReg,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [2:0] ImmSrc,
    output logic       trap,
    output logic [1:0] trap_cause,
    output logic       retire,
    output logic [3:0] st_dbg
`ifdef CTRL_INSTRET_EN
    ,output logic [INSTRET_W-1:0] instret
`endif
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC   = 4'd3,
        S_MEM_RD = 4'd4,
        S_WB     = 4'd5,
        S_MEM_WR = 4'd6,
        S_JUMP   = 4'd7,
        S_BRANCH = 4'd8,
        S_TRAP   = 4'd9
    } state_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int                 TW1      = TIMEOUT_W + 1;
    localparam logic [TIMEOUT_W:0] TMAX_EXT = TW1'(TIMEOUT_MAX);

    state_t               state_q, state_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [1:0]           trap_cause_q, trap_cause_d;
    logic [TIMEOUT_W-1:0] wait_inc;
    logic                 timeout_hit;

    // funct fields are resolved by the ALU decoder, not here
    wire unused_funct = ^{funct3, funct7};

    // Saturating increment so a stalled access can never wrap back under the limit
    assign wait_inc    = (&wait_q) ? wait_q : wait_q + TIMEOUT_W'(1);
    // Fires on the cycle whose miss would bring the count to TIMEOUT_MAX; only consulted
    // after mem_ready, so a same-cycle completion always wins
    assign timeout_hit = (TIMEOUT_MAX != 0) && (({1'b0, wait_q} + TW1'(1)) >= TMAX_EXT);

    assign trap_cause = trap_cause_q;
    assign st_dbg     = state_q;

    always_comb begin
        state_d      = state_q;
        wait_d       = '0;
        trap_cause_d = trap_cause_q;
        mem_req      = 1'b0;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        RegWrite     = 1'b0;
        IorD         = 1'b0;
        IRWrite      = 1'b0;
        LatchAB      = 1'b0;
        ALUOutEn     = 1'b0;
        PCSource     = 2'b00;
        MemtoReg     = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        ALUOp        = 2'b00;
        ImmSrc       = 3'd0;
        trap         = 1'b0;
        retire       = 1'b0;

        case (state_q)
            S_RESET: state_d = S_FETCH;

            S_FETCH: begin
                mem_req = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    IRWrite  = 1'b1;
                    PCWrite  = 1'b1;
                    ALUSrcB  = 2'b01;
                    ALUOutEn = 1'b1;
                    state_d  = S_DECODE;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd2;
                end else begin
                    wait_d = wait_inc;
                end
            end

            S_DECODE: begin
                LatchAB = 1'b1;
                case (opcode)
                    OPC_OPIMM, OPC_LOAD, OPC_JALR: ImmSrc = 3'd0;
                    OPC_STORE:                     ImmSrc = 3'd1;
                    OPC_BRANCH:                    ImmSrc = 3'd2;
                    OPC_LUI, OPC_AUIPC:            ImmSrc = 3'd3;
                    OPC_JAL:                       ImmSrc = 3'd4;
                    default:                       ImmSrc = 3'd0;
                endcase
                case (opcode)
                    OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC,
                    OPC_LOAD, OPC_STORE, OPC_JALR: state_d = S_EXEC;
                    OPC_BRANCH:                    state_d = S_BRANCH;
                    OPC_JAL:                       state_d = S_JUMP;
                    default: begin
                        state_d      = S_TRAP;
                        trap_cause_d = 2'd1;
                    end
                endcase
            end

            S_EXEC: begin
                ALUOutEn = 1'b1;
                case (opcode)
                    OPC_OP:    begin ALUSrcA = 2'b01; ALUSrcB = 2'b00; ALUOp = 2'b10; end
                    OPC_OPIMM: begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUOp = 2'b11; end
                    OPC_LOAD, OPC_STORE, OPC_JALR:
                               begin ALUSrcA = 2'b01; ALUSrcB = 2'b10; ALUOp = 2'b00; end
                    default:   begin ALUSrcA = 2'b00; ALUSrcB = 2'b10; ALUOp = 2'b00; end
                endcase
                case (opcode)
                    OPC_LOAD:  state_d = S_MEM_RD;
                    OPC_STORE: state_d = S_MEM_WR;
                    OPC_JALR:  state_d = S_JUMP;
                    default:   state_d = S_WB;
                endcase
            end

            S_MEM_RD, S_MEM_WR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemRead  = (state_q == S_MEM_RD);
                MemWrite = (state_q == S_MEM_WR);
                if (mem_ready) begin
                    // A store is finished once memory accepts it
                    retire  = (state_q == S_MEM_WR);
                    state_d = (state_q == S_MEM_RD) ? S_WB : S_FETCH;
                end else if (timeout_hit) begin
                    state_d      = S_TRAP;
                    trap_cause_d = 2'd2;
                end else begin
                    wait_d = wait_inc;
                end
            end

            S_WB: begin
                RegWrite = 1'b1;
                MemtoReg = (opcode == OPC_LOAD) ? 2'b01 : 2'b00;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            S_BRANCH: begin
                ALUSrcA     = 2'b01;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                retire      = 1'b1;
                state_d     = S_FETCH;
            end

            S_JUMP: begin
                PCWrite  = 1'b1;
                RegWrite = 1'b1;
                MemtoReg = 2'b10;
                PCSource = (opcode == OPC_JAL) ? 2'b01 : 2'b10;
                retire   = 1'b1;
                state_d  = S_FETCH;
            end

            S_TRAP: begin
                trap = 1'b1;
                if (trap_clear) begin
                    state_d      = S_FETCH;
                    trap_cause_d = 2'd0;
                end
            end

            default: state_d = S_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_RESET;
            wait_q       <= '0;
            trap_cause_q <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            trap_cause_q <= trap_cause_d;
        end
    end

`ifdef CTRL_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q, instret_d;

    always_comb begin
        instret_d = instret_q;
        if (retire) instret_d = instret_q + INSTRET_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) instret_q <= '0;
        else          instret_q <= instret_d;
    end

    assign instret = instret_q;
`endif

endmodule

// File: tb/tb_control_multiciclo_hs.sv
// tb/tb_control_multiciclo_hs.sv - scoreboard bench for control_multiciclo_hs
module tb_control_multiciclo_hs;

    localparam int TMAX = 6;
    localparam int IW   = 4;

    localparam logic [6:0] OP     = 7'h33;
    localparam logic [6:0] OPIMM  = 7'h13;
    localparam logic [6:0] LUI    = 7'h37;
    localparam logic [6:0] AUIPC  = 7'h17;
    localparam logic [6:0] LOAD   = 7'h03;
    localparam logic [6:0] STORE  = 7'h23;
    localparam logic [6:0] JALR   = 7'h67;
    localparam logic [6:0] BRANCH = 7'h63;
    localparam logic [6:0] JAL    = 7'h6F;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req, pcw, pcwc, mrd, mwr, rw, iord, irw, lab, aoe;
        logic [1:0] pcs, m2r, asa, asb, aop;
        logic [2:0] imm;
        logic       trap;
        logic [1:0] cause;
        logic       retire;
    } ctl_t;

    logic       clk, reset_n, mem_ready, trap_clear;
    logic [6:0] opcode, funct7;
    logic [2:0] funct3;
    logic       mem_req, PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite, IorD, IRWrite, LatchAB, ALUOutEn;
    logic [1:0] PCSource, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, trap_cause;
    logic [2:0] ImmSrc;
    logic       trap, retire;
    logic [3:0] st_dbg;
`ifdef CTRL_INSTRET_EN
    logic [IW-1:0] instret;
    logic [IW-1:0] ret_cnt;
`endif

    int   n_cmp = 0;
    int   n_bad = 0;
    ctl_t exp_q[$];
    logic [6:0] cur_opc;

    control_multiciclo_hs #(
        .TIMEOUT_W(8), .TIMEOUT_MAX(TMAX)
`ifdef CTRL_INSTRET_EN
        , .INSTRET_W(IW)
`endif
    ) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct3(funct3), .funct7(funct7),
        .mem_ready(mem_ready), .trap_clear(trap_clear), .mem_req(mem_req),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .MemRead(MemRead), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IorD(IorD), .IRWrite(IRWrite), .LatchAB(LatchAB), .ALUOutEn(ALUOutEn),
        .PCSource(PCSource), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
        .ImmSrc(ImmSrc), .trap(trap), .trap_cause(trap_cause), .retire(retire), .st_dbg(st_dbg)
`ifdef CTRL_INSTRET_EN
        , .instret(instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t sample();
        return {st_dbg, mem_req, PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite, IorD, IRWrite,
                LatchAB, ALUOutEn, PCSource, MemtoReg, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, trap,
                trap_cause, retire};
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Reference model: what each phase of an instruction must look like on the control vector
    function automatic ctl_t mem_v(input int kind, input logic rdy);
        ctl_t v = '0;
        v.st = 4'(kind);
        v.mem_req = 1'b1;
        if (kind == 1) begin
            v.mrd = 1'b1;
            if (rdy) begin v.irw = 1'b1; v.pcw = 1'b1; v.asb = 2'b01; v.aoe = 1'b1; end
        end else begin
            v.iord = 1'b1;
            if (kind == 4) v.mrd = 1'b1;
            else begin v.mwr = 1'b1; v.retire = rdy; end
        end
        return v;
    endfunction

    function automatic ctl_t decode_v(input logic [6:0] opc);
        ctl_t v = '0;
        v.st = 4'd2; v.lab = 1'b1;
        if (opc == STORE) v.imm = 3'd1;
        else if (opc == BRANCH) v.imm = 3'd2;
        else if (opc == LUI || opc == AUIPC) v.imm = 3'd3;
        else if (opc == JAL) v.imm = 3'd4;
        return v;
    endfunction

    function automatic ctl_t exec_v(input logic [6:0] opc);
        ctl_t v = '0;
        v.st = 4'd3; v.aoe = 1'b1;
        if (opc == OP) begin v.asa = 2'b01; v.asb = 2'b00; v.aop = 2'b10; end
        else if (opc == OPIMM) begin v.asa = 2'b01; v.asb = 2'b10; v.aop = 2'b11; end
        else if (opc == LUI || opc == AUIPC) begin v.asa = 2'b00; v.asb = 2'b10; v.aop = 2'b00; end
        else begin v.asa = 2'b01; v.asb = 2'b10; v.aop = 2'b00; end
        return v;
    endfunction

    function automatic ctl_t wb_v(input logic [6:0] opc);
        ctl_t v = '0;
        v.st = 4'd5; v.rw = 1'b1; v.retire = 1'b1;
        v.m2r = (opc == LOAD) ? 2'b01 : 2'b00;
        return v;
    endfunction

    function automatic ctl_t br_v();
        ctl_t v = '0;
        v.st = 4'd8; v.asa = 2'b01; v.aop = 2'b01; v.pcwc = 1'b1; v.pcs = 2'b01; v.retire = 1'b1;
        return v;
    endfunction

    function automatic ctl_t jump_v(input logic [6:0] opc);
        ctl_t v = '0;
        v.st = 4'd7; v.pcw = 1'b1; v.rw = 1'b1; v.m2r = 2'b10; v.retire = 1'b1;
        v.pcs = (opc == JAL) ? 2'b01 : 2'b10;
        return v;
    endfunction

    function automatic ctl_t trap_v(input logic [1:0] cause);
        ctl_t v = '0;
        v.st = 4'd9; v.trap = 1'b1; v.cause = cause;
        return v;
    endfunction

    // One clock of stimulus: drive inputs just after the edge and queue the expected vector
    task automatic step(input ctl_t e, input logic rdy, input logic tclr);
        @(posedge clk); #1;
        mem_ready  = rdy;
        trap_clear = tclr;
        opcode     = cur_opc;
        funct3     = 3'($urandom);
        funct7     = 7'($urandom);
        exp_q.push_back(e);
    endtask

    task automatic do_trap(input logic [1:0] cause);
        int hold = $urandom_range(0, 2);
        for (int i = 0; i < hold; i++) step(trap_v(cause), rnd1(), 1'b0);
        step(trap_v(cause), rnd1(), 1'b1);
    endtask

    // n = not-ready cycles before mem_ready; n >= TMAX means memory never answers in time
    task automatic mem_phase(input int kind, input int n, output bit ok);
        int lim = (n >= TMAX) ? TMAX : n;
        for (int i = 0; i < lim; i++) step(mem_v(kind, 1'b0), 1'b0, rnd1());
        if (n >= TMAX) begin
            ok = 1'b0;
            do_trap(2'd2);
        end else begin
            step(mem_v(kind, 1'b1), 1'b1, rnd1());
            ok = 1'b1;
        end
    endtask

    task automatic run_instr(input logic [6:0] opc, input int fw, input int mw);
        bit ok;
        cur_opc = opc;
        mem_phase(1, fw, ok);
        if (!ok) return;
        step(decode_v(opc), rnd1(), rnd1());
        case (opc)
            OP, OPIMM, LUI, AUIPC, LOAD, STORE, JALR: begin
                step(exec_v(opc), rnd1(), rnd1());
                if (opc == LOAD) begin
                    mem_phase(4, mw, ok);
                    if (ok) step(wb_v(opc), rnd1(), rnd1());
                end else if (opc == STORE) begin
                    mem_phase(6, mw, ok);
                end else if (opc == JALR) begin
                    step(jump_v(opc), rnd1(), rnd1());
                end else begin
                    step(wb_v(opc), rnd1(), rnd1());
                end
            end
            BRANCH: step(br_v(), rnd1(), rnd1());
            JAL:    step(jump_v(opc), rnd1(), rnd1());
            default: do_trap(2'd1);
        endcase
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        reset_n = 1'b1;
        mem_ready = rnd1();
        trap_clear = rnd1();
        exp_q.push_back('0);
    endtask

    task automatic check_zero(input string name);
        ctl_t a = sample();
        n_cmp++;
        if (a !== '0) begin
            n_bad++;
            $display("FAIL %s: got %h want 0", name, a);
        end
`ifdef CTRL_INSTRET_EN
        n_cmp++;
        if (instret !== '0) begin
            n_bad++;
            $display("FAIL %s_instret: got %0d want 0", name, instret);
        end
`endif
    endtask

    function automatic int pick_wait();
        int r = $urandom_range(0, 9);
        if (r == 0) return TMAX;
        if (r == 1) return TMAX - 1;
        return $urandom_range(0, 2);
    endfunction

    // Monitor: every cycle that has an expectation queued, compare what the DUT presents
    initial begin
        ctl_t e, a;
`ifdef CTRL_INSTRET_EN
        ret_cnt = '0;
`endif
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = sample();
                n_cmp++;
                if (a !== e) begin
                    n_bad++;
                    $display("FAIL ctl_vec t=%0t st=%0d: got %h want %h", $time, st_dbg, a, e);
                end
`ifdef CTRL_INSTRET_EN
                if (e.st == 4'd0) ret_cnt = '0;
                n_cmp++;
                if (instret !== ret_cnt) begin
                    n_bad++;
                    $display("FAIL instret t=%0t: got %0d want %0d", $time, instret, ret_cnt);
                end
                if (e.retire) ret_cnt = ret_cnt + 1'b1;
`endif
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish, %0d expectations pending", exp_q.size());
        $fatal(1);
    end

    initial begin
        logic [6:0] opcs[13];
        bit ok;
        opcs = '{OP, OPIMM, LUI, AUIPC, LOAD, STORE, JALR, BRANCH, JAL, 7'h7F, 7'h00, 7'h0F, 7'h73};
        reset_n = 1'b0; mem_ready = 1'b0; trap_clear = 1'b0;
        opcode = OP; funct3 = '0; funct7 = '0; cur_opc = OP;
        #2;
        check_zero("reset_state");
        release_reset();

        run_instr(OP, 0, 0);            // ADD x3,x1,x2: 1,2,3,5
        run_instr(LOAD, 3, 5);          // LW with delayed fetch and read
        run_instr(7'h7F, 0, 0);         // illegal opcode trap
        run_instr(OP, TMAX, 0);         // fetch timeout trap
        run_instr(OP, TMAX - 1, 0);     // ready on the last allowed wait cycle
        run_instr(BRANCH, 0, 0);
        run_instr(JAL, 1, 0);
        run_instr(JALR, 0, 0);
        run_instr(STORE, 2, 1);
        run_instr(LUI, 0, 0);
        run_instr(AUIPC, 0, 0);
        run_instr(OPIMM, 0, 0);
        run_instr(LOAD, 0, TMAX);       // read timeout
        run_instr(STORE, 0, TMAX);      // write timeout, no retire
        run_instr(STORE, 0, TMAX - 1);

        for (int i = 0; i < 80; i++)
            run_instr(opcs[$urandom_range(0, 12)], pick_wait(), pick_wait());

        // Asynchronous reset in the middle of a pending store
        cur_opc = STORE;
        mem_phase(1, 0, ok);
        step(decode_v(STORE), 1'b0, 1'b0);
        step(exec_v(STORE), 1'b0, 1'b0);
        step(mem_v(6, 1'b0), 1'b0, 1'b0);
        #6;
        reset_n = 1'b0;
        #1;
        check_zero("async_reset_mid_store");
        release_reset();
        run_instr(OP, 0, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/control_multiciclo_hs.md
Name: control_multiciclo_hs

Overview:
- Parametrised multicycle RV32I control FSM, successor to the current global controller.
- Adds a variable-latency memory handshake (mem_req/mem_ready) with timeout and an illegal-instruction/bus-timeout trap state.
- Adds a dedicated branch state and a retired-instruction pulse.
- Sits between the IR fields of the datapath and the datapath/memory enables. Drives the same control vector as the current controller.

Parameters:
- TIMEOUT_W, 8, width of the memory-wait counter.
- TIMEOUT_MAX, 200, wait cycles before a bus-timeout trap; 0 disables the timeout.
- INSTRET_W, 32, width of the retired-instruction counter (optional feature only).

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous active-low reset
- opcode  in  7  IR[6:0]
- funct3  in  3  IR[14:12]
- funct7  in  7  IR[31:25]
- mem_ready  in  1  memory access complete this cycle
- trap_clear  in  1  leave TRAP, resume fetch
- mem_req  out  1  memory request; held until mem_ready
- PCWrite, PCWriteCond, MemRead, MemWrite, RegWrite, IorD, IRWrite, LatchAB, ALUOutEn  out  1 each  datapath enables
- PCSource, MemtoReg, ALUSrcA, ALUSrcB, ALUOp  out  2 each  datapath selects
- ImmSrc  out  3  0=I 1=S 2=B 3=U 4=J
- trap  out  1  high while in TRAP
- trap_cause  out  2  0 none, 1 illegal opcode, 2 bus timeout
- retire  out  1  one-cycle pulse per completed instruction
- st_dbg  out  4  current state encoding

Behaviour:
- Reset (reset_n low, async):
  - state=RESET; all outputs 0; wait counter 0; trap_cause 0.
  - RESET always goes to FETCH on the next clock.
- State encodings: RESET=0, FETCH=1, DECODE=2, EXEC=3, MEM_RD=4, WB=5, MEM_WR=6, JUMP=7, BRANCH=8, TRAP=9. st_dbg equals the encoding.
- FETCH:
  - mem_req=1, MemRead=1, IorD=0 throughout.
  - Remain in FETCH while mem_ready=0.
  - In the mem_ready cycle: IRWrite=1, PCWrite=1, PCSource=00, ALUSrcA=00, ALUSrcB=01, ALUOp=00, ALUOutEn=1; next state DECODE.
- DECODE:
  - LatchAB=1; ImmSrc decoded from opcode.
  - Next state by opcode:
    - OP, OP-IMM, LUI, AUIPC, LOAD, STORE, JALR → EXEC
    - BRANCH → BRANCH
    - JAL → JUMP
    - anything else → TRAP with cause 1
- EXEC:
  - ALUOutEn=1. Selects as follows:
    - OP: ALUSrcA=01, ALUSrcB=00, ALUOp=10
    - OP-IMM: 01/10/11
    - LOAD, STORE, JALR: 01/10/00
    - LUI: 00/10/00
    - AUIPC: 00/10/00
  - Next state: LOAD→MEM_RD, STORE→MEM_WR, JALR→JUMP, else WB.
- MEM_RD / MEM_WR:
  - mem_req=1, IorD=1, plus MemRead or MemWrite respectively, held until mem_ready.
  - On mem_ready: MEM_RD→WB; MEM_WR→FETCH with retire=1.
- WB:
  - RegWrite=1. MemtoReg=01 for LOAD, else 00.
  - retire=1; next state FETCH.
- BRANCH:
  - ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01.
  - retire=1; next state FETCH.
- JUMP:
  - PCWrite=1, RegWrite=1, MemtoReg=10.
  - PCSource=01 for JAL, 10 for JALR.
  - retire=1; next state FETCH.
- Memory timeout:
  - Wait counter clears on entry to any memory state and on mem_ready.
  - It increments each cycle in FETCH/MEM_RD/MEM_WR while mem_ready=0.
  - When the counter reaches TIMEOUT_MAX (with TIMEOUT_MAX≠0), next state is TRAP with cause 2, and mem_req drops that same next cycle.
  - The counter saturates and never wraps.
- TRAP:
  - trap=1; trap_cause held; all enables 0.
  - trap_clear=1 → FETCH, and trap_cause cleared on the transition.
  - If mem_ready arrives in the same cycle the timeout is reached, mem_ready wins: the access completes and there is no trap.
- funct3/funct7 are not decoded here; the ALU decoder resolves them.
- Reset asserted mid-access aborts immediately. mem_req drops asynchronously.

Optional Feature:
- Macro CTRL_INSTRET_EN.
- Defined: adds output port instret [INSTRET_W-1:0].
  - Increments on every retire pulse; wraps modulo 2^INSTRET_W; reset value 0.
  - Not incremented by trapped instructions.
- Undefined: port and counter are absent; all other behaviour is unchanged.

Test Plan:
- ADD x3,x1,x2 (0x002081B3) with mem_ready tied 1 → states 1,2,3,5,1. IRWrite and PCWrite pulse in FETCH; RegWrite in WB; retire=1 once; 4 cycles per instruction.
- LW with mem_ready delayed 3 cycles in FETCH and 5 in MEM_RD → mem_req held high for 4 and 6 cycles respectively; IRWrite high only on the ready cycle; WB has MemtoReg=01.
- Opcode 0x7F → DECODE→TRAP, trap=1, trap_cause=1. Pulse trap_clear → FETCH next cycle, trap_cause=0.
- TIMEOUT_MAX=4, mem_ready held 0 in FETCH → TRAP entered after 4 wait cycles, cause 2. A second run with mem_ready arriving on the 4th wait cycle → DECODE, no trap.
- BEQ → state 8: PCWriteCond=1, PCSource=01, retire=1. JAL → state 7: PCWrite=1, PCSource=01, MemtoReg=10, RegWrite=1.
- With CTRL_INSTRET_EN, INSTRET_W=4: run 17 instructions → instret=1 (wrapped). Drop reset_n mid MEM_WR → all outputs 0 immediately, instret=0.
